// File: rtl/chk_pkg.sv
// -----------------------------------------------------------------------------
// chk_pkg
//   Shared definitions for the store stream checker:
//   - checker state encodings (ST_IDLE .. ST_TIMEOUT), also the 'state' output
//   - failure codes reported on 'fail_code'
//   - default completion-marker and scratch-range constants
// -----------------------------------------------------------------------------
package chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } chk_state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISMATCH   = 2'd1,
        FC_OVERRUN    = 2'd2,
        FC_EARLY_DONE = 2'd3
    } fail_code_e;

    // Completion marker: the test program writes DONE_DATA to DONE_ADDR.
    localparam int unsigned DEF_DONE_ADDR = 40;
    localparam int unsigned DEF_DONE_DATA = 30;

    // Scratch window the program may write freely; never checked.
    localparam int unsigned DEF_IGN_LO = 96;
    localparam int unsigned DEF_IGN_HI = 99;

endpackage

// File: rtl/chk_table_ram.sv
// -----------------------------------------------------------------------------
// chk_table_ram
//   Expected-store table: DEPTH x W, synchronous write, asynchronous read so
//   the checker can compare a store against the entry at its pointer in the
//   same cycle (maps to distributed RAM).
// Ports:
//   clk_i    write clock, rising edge
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational)
// -----------------------------------------------------------------------------
module chk_table_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned W     = 65
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // No reset: contents survive reset so a run can be repeated without reload.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_stream_checker.sv
// -----------------------------------------------------------------------------
// store_stream_checker
//   Watches the core's data-memory write port and checks each store, in order,
//   against a loadable table of expected (address, data, counted) entries.
//   Stores to a scratch window are skipped, a marker store ends the run, and a
//   watchdog flags a core that stops storing. Result states are sticky.
// Ports:
//   clk, reset (async, active low)
//   tbl_we/tbl_idx/tbl_addr/tbl_data/tbl_cnt  table load (IDLE only)
//   tbl_len, tmo_limit                        sampled on start
//   start                                     IDLE -> RUN, or terminal -> IDLE
//   MemWrite/DataAdr/WriteData                observed store port
//   state, pass_count, exp_ptr                progress
//   fail_addr, fail_data, fail_code           first-failure capture
// -----------------------------------------------------------------------------
module store_stream_checker
    import chk_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TMO_W     = 16,
    parameter int unsigned DONE_ADDR = DEF_DONE_ADDR,
    parameter int unsigned DONE_DATA = DEF_DONE_DATA,
    parameter int unsigned IGN_LO    = DEF_IGN_LO,
    parameter int unsigned IGN_HI    = DEF_IGN_HI
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              tbl_cnt,
    input  logic [IDX_W:0]    tbl_len,
    input  logic              start,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  pass_count,
    output logic [IDX_W:0]    exp_ptr,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [1:0]        fail_code
);

    localparam int unsigned ENT_W = ADDR_W + DATA_W + 1;

    localparam logic [ADDR_W-1:0] DONE_A = ADDR_W'(DONE_ADDR);
    localparam logic [DATA_W-1:0] DONE_D = DATA_W'(DONE_DATA);
    localparam logic [ADDR_W-1:0] IGN_L  = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_H  = ADDR_W'(IGN_HI);

    chk_state_e        state_q;
    fail_code_e        fail_code_q;
    logic [CNT_W-1:0]  pass_cnt_q;
    logic [IDX_W:0]    ptr_q;
    logic [IDX_W:0]    len_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  wd_q;
    logic [TMO_W-1:0]  wd_d;

    logic [ENT_W-1:0]  rd_ent;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_cnt;

    logic              is_done;
    logic              is_ign;
    logic              is_match;
    logic              at_end;

    // ------------------------------------------------------------------
    // Expected table. Entry layout: {addr, data, counted}.
    // ------------------------------------------------------------------
    chk_table_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .W     (ENT_W)
    ) u_table (
        .clk_i   (clk),
        .we_i    (tbl_we && (state_q == ST_IDLE)),
        .waddr_i (tbl_idx),
        .wdata_i ({tbl_addr, tbl_data, tbl_cnt}),
        .raddr_i (ptr_q[IDX_W-1:0]),
        .rdata_o (rd_ent)
    );

    assign {exp_addr, exp_data, exp_cnt} = rd_ent;

    // Store classification; priority is resolved in the FSM below.
    assign is_done  = (DataAdr == DONE_A) && (WriteData == DONE_D);
    assign is_ign   = (DataAdr >= IGN_L) && (DataAdr <= IGN_H);
    assign at_end   = (ptr_q == len_q);
    assign is_match = (DataAdr == exp_addr) && (WriteData == exp_data);
    assign wd_d     = wd_q + TMO_W'(1);

    // ------------------------------------------------------------------
    // Checker FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fail_code_q <= FC_NONE;
            pass_cnt_q  <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            tmo_q       <= '0;
            wd_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        len_q       <= tbl_len;
                        tmo_q       <= tmo_limit;
                        fail_code_q <= FC_NONE;
                        pass_cnt_q  <= '0;
                        ptr_q       <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        wd_q        <= '0;
                    end
                end

                ST_RUN: begin
                    if (MemWrite) begin
                        // Any store, even an ignored one, proves the core is alive.
                        wd_q <= '0;
                        if (is_done) begin
                            if (at_end) begin
                                state_q <= ST_PASS;
                            end else begin
                                state_q     <= ST_FAIL;
                                fail_code_q <= FC_EARLY_DONE;
                                fail_addr_q <= DataAdr;
                                fail_data_q <= WriteData;
                            end
                        end else if (is_ign) begin
                            // scratch store: skip
                        end else if (at_end) begin
                            state_q     <= ST_FAIL;
                            fail_code_q <= FC_OVERRUN;
                            fail_addr_q <= DataAdr;
                            fail_data_q <= WriteData;
                        end else if (is_match) begin
                            ptr_q <= ptr_q + 1'b1;
                            if (exp_cnt && (pass_cnt_q != '1)) begin
                                pass_cnt_q <= pass_cnt_q + 1'b1;
                            end
                        end else begin
                            state_q     <= ST_FAIL;
                            fail_code_q <= FC_MISMATCH;
                            fail_addr_q <= DataAdr;
                            fail_data_q <= WriteData;
                        end
                    end else if (tmo_q != '0) begin
                        // Counting only while enabled keeps the counter from
                        // wrapping during long disabled runs.
                        wd_q <= wd_d;
                        if (wd_d == tmo_q) begin
                            state_q <= ST_TIMEOUT;
                        end
                    end
                end

                default: begin
                    // PASS / FAIL / TIMEOUT hold until start clears back to IDLE.
                    if (start) begin
                        state_q     <= ST_IDLE;
                        fail_code_q <= FC_NONE;
                        pass_cnt_q  <= '0;
                        ptr_q       <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        wd_q        <= '0;
                    end
                end
            endcase
        end
    end

    assign state      = state_q;
    assign pass_count = pass_cnt_q;
    assign exp_ptr    = ptr_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_store_stream_checker.sv
module tb_store_stream_checker;

    logic        clk;
    logic        reset;
    logic        tbl_we;
    logic [5:0]  tbl_idx;
    logic [31:0] tbl_addr;
    logic [31:0] tbl_data;
    logic        tbl_cnt;
    logic [6:0]  tbl_len;
    logic        start;
    logic [15:0] tmo_limit;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [2:0]  state;
    logic [7:0]  pass_count;
    logic [6:0]  exp_ptr;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;
    logic [1:0]  fail_code;

    int vecs = 0;
    int errs = 0;

    // Reference table and store stream
    logic [31:0] m_a [64];
    logic [31:0] m_d [64];
    logic        m_c [64];
    int          m_len;
    logic [31:0] q_a [$];
    logic [31:0] q_d [$];

    logic [83:0] obs;
    logic [83:0] exp_t;
    assign obs = {state, pass_count, exp_ptr, fail_code, fail_addr, fail_data};

    store_stream_checker dut (
        .clk        (clk),
        .reset      (reset),
        .tbl_we     (tbl_we),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .tbl_cnt    (tbl_cnt),
        .tbl_len    (tbl_len),
        .start      (start),
        .tmo_limit  (tmo_limit),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .state      (state),
        .pass_count (pass_count),
        .exp_ptr    (exp_ptr),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_code  (fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [83:0] tup(input int s, input int pc, input int p,
                                        input int fc, input logic [31:0] fa,
                                        input logic [31:0] fd);
        logic [2:0] s3  = s[2:0];
        logic [7:0] pc8 = pc[7:0];
        logic [6:0] p7  = p[6:0];
        logic [1:0] fc2 = fc[1:0];
        return {s3, pc8, p7, fc2, fa, fd};
    endfunction

    // ---- stimulus helpers (drive only, at the falling edge) ----
    task automatic step();
        @(negedge clk);
        tbl_we = 1'b0; start = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d, input logic c);
        step();
        tbl_we = 1'b1; tbl_idx = idx[5:0]; tbl_addr = a; tbl_data = d; tbl_cnt = c;
        m_a[idx] = a; m_d[idx] = d; m_c[idx] = c;
    endtask

    task automatic go(input int len, input int tmo);
        step();
        start = 1'b1; tbl_len = len[6:0]; tmo_limit = tmo[15:0]; m_len = len;
    endtask

    task automatic go_wr(input int len, input int idx, input logic [31:0] a, input logic [31:0] d, input logic c);
        go(len, 0);
        tbl_we = 1'b1; tbl_idx = idx[5:0]; tbl_addr = a; tbl_data = d; tbl_cnt = c;
        m_a[idx] = a; m_d[idx] = d; m_c[idx] = c;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        step();
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
    endtask

    // From a sticky result state back to IDLE; outputs must be cleared.
    task automatic restart();
        step();
        start = 1'b1;
        step();
        vecs++;
        if (obs !== tup(0, 0, 0, 0, 0, 0)) begin
            errs++; $display("FAIL restart_idle: got %h want %h", obs, tup(0, 0, 0, 0, 0, 0));
        end
    endtask

    // Behavioural model: walk the store list applying the rules in order.
    task automatic model(output logic [83:0] e);
        int s = 1, pc = 0, p = 0, fc = 0;
        logic [31:0] fa = 0, fd = 0;
        for (int i = 0; i < q_a.size(); i++) begin
            if (s != 1) break;
            if (q_a[i] == 32'd40 && q_d[i] == 32'd30) begin
                if (p == m_len) s = 2;
                else begin s = 3; fc = 3; fa = q_a[i]; fd = q_d[i]; end
            end else if (q_a[i] >= 32'd96 && q_a[i] <= 32'd99) begin
                // scratch
            end else if (p == m_len) begin
                s = 3; fc = 2; fa = q_a[i]; fd = q_d[i];
            end else if (q_a[i] == m_a[p] && q_d[i] == m_d[p]) begin
                if (m_c[p] && pc < 255) pc++;
                p++;
            end else begin
                s = 3; fc = 1; fa = q_a[i]; fd = q_d[i];
            end
        end
        e = tup(s, pc, p, fc, fa, fd);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b0; tbl_we = 0; start = 0; MemWrite = 0; tbl_idx = 0; tbl_addr = 0;
        tbl_data = 0; tbl_cnt = 0; tbl_len = 0; tmo_limit = 0; DataAdr = 0; WriteData = 0;
        step(); step();
        vecs++;
        if (obs !== tup(0, 0, 0, 0, 0, 0)) begin
            errs++; $display("FAIL reset_state: got %h want %h", obs, tup(0, 0, 0, 0, 0, 0));
        end
        reset = 1'b1;
    endtask

    task automatic test_pass();
        load(0, 100, 25, 1); load(1, 104, 4096, 1); load(2, 108, 4184, 0);
        go(3, 0);
        st(100, 25); st(104, 4096); st(108, 4184); st(40, 30);
        step();
        vecs++;
        if (obs !== tup(2, 2, 3, 0, 0, 0)) begin
            errs++; $display("FAIL pass_basic: got %h want %h", obs, tup(2, 2, 3, 0, 0, 0));
        end
    endtask

    task automatic test_mismatch();
        restart();
        go(3, 0);
        st(100, 25); st(104, 4097);
        step();
        vecs++;
        if (obs !== tup(3, 1, 1, 1, 104, 4097)) begin
            errs++; $display("FAIL mismatch: got %h want %h", obs, tup(3, 1, 1, 1, 104, 4097));
        end
        // Sticky: later stores, even the marker, change nothing.
        st(108, 4184); st(40, 30);
        step();
        vecs++;
        if (obs !== tup(3, 1, 1, 1, 104, 4097)) begin
            errs++; $display("FAIL fail_sticky: got %h want %h", obs, tup(3, 1, 1, 1, 104, 4097));
        end
    endtask

    task automatic test_ignore();
        restart();
        go(3, 0);
        st(97, 1); st(100, 25); st(96, 7); st(99, 8); st(104, 4096); st(98, 0);
        st(108, 4184); st(40, 30);
        step();
        vecs++;
        if (obs !== tup(2, 2, 3, 0, 0, 0)) begin
            errs++; $display("FAIL ignore_range: got %h want %h", obs, tup(2, 2, 3, 0, 0, 0));
        end
    endtask

    task automatic test_early_done_overrun();
        restart();
        go(3, 0);
        st(100, 25); st(40, 30);
        step();
        vecs++;
        if (obs !== tup(3, 1, 1, 3, 40, 30)) begin
            errs++; $display("FAIL early_done: got %h want %h", obs, tup(3, 1, 1, 3, 40, 30));
        end
        restart();
        go(3, 0);
        st(100, 25); st(104, 4096); st(108, 4184); st(112, 5);
        step();
        vecs++;
        if (obs !== tup(3, 2, 3, 2, 112, 5)) begin
            errs++; $display("FAIL overrun: got %h want %h", obs, tup(3, 2, 3, 2, 112, 5));
        end
        // Zero-length table: scratch store skipped, next real store overruns.
        restart();
        go(0, 0);
        st(96, 1); st(100, 25);
        step();
        vecs++;
        if (obs !== tup(3, 0, 0, 2, 100, 25)) begin
            errs++; $display("FAIL len_zero: got %h want %h", obs, tup(3, 0, 0, 2, 100, 25));
        end
    endtask

    task automatic test_timeout();
        restart();
        go(3, 10);
        repeat (10) step();
        vecs++;
        if (state !== 3'd1) begin
            errs++; $display("FAIL timeout_early: got %0d want 1", state);
        end
        step();
        vecs++;
        if (obs !== tup(4, 0, 0, 0, 0, 0)) begin
            errs++; $display("FAIL timeout_10: got %h want %h", obs, tup(4, 0, 0, 0, 0, 0));
        end
        // A store landing on the limit cycle wins and restarts the count.
        restart();
        go(3, 5);
        repeat (4) step();
        st(100, 25);
        step();
        vecs++;
        if (obs !== tup(1, 1, 1, 0, 0, 0)) begin
            errs++; $display("FAIL store_wins: got %h want %h", obs, tup(1, 1, 1, 0, 0, 0));
        end
        repeat (4) step();
        vecs++;
        if (state !== 3'd1) begin
            errs++; $display("FAIL timeout2_early: got %0d want 1", state);
        end
        step();
        vecs++;
        if (obs !== tup(4, 1, 1, 0, 0, 0)) begin
            errs++; $display("FAIL timeout2: got %h want %h", obs, tup(4, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_wd_disabled();
        restart();
        go(3, 0);
        repeat (1000) step();
        vecs++;
        if (obs !== tup(1, 0, 0, 0, 0, 0)) begin
            errs++; $display("FAIL wd_disabled: got %h want %h", obs, tup(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        st(100, 25);
        step();
        #2 reset = 1'b0;
        #1;
        vecs++;
        if (obs !== tup(0, 0, 0, 0, 0, 0)) begin
            errs++; $display("FAIL async_reset: got %h want %h", obs, tup(0, 0, 0, 0, 0, 0));
        end
        step();
        reset = 1'b1;
        go(3, 0);
        st(100, 25); st(104, 4096); st(108, 4184); st(40, 30);
        step();
        vecs++;
        if (obs !== tup(2, 2, 3, 0, 0, 0)) begin
            errs++; $display("FAIL table_retained: got %h want %h", obs, tup(2, 2, 3, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int n, k, endc;
            step(); reset = 1'b0;
            step(); reset = 1'b1;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n - 1; i++)
                load(i, ($urandom & 32'hFFFF_FFFC) | 32'h0001_0000, $urandom, 1'($urandom_range(0, 1)));
            // last entry written in the same cycle as start
            go_wr(n, n - 1, ($urandom & 32'hFFFF_FFFC) | 32'h0001_0000, $urandom, 1'($urandom_range(0, 1)));
            q_a.delete(); q_d.delete();
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    q_a.push_back(32'd96 + $urandom_range(0, 3)); q_d.push_back($urandom);
                end
                q_a.push_back(m_a[i]);
                q_d.push_back(($urandom_range(0, 11) == 0) ? (m_d[i] ^ 32'd1) : m_d[i]);
            end
            endc = $urandom_range(0, 3);
            if (endc <= 1) begin q_a.push_back(32'd40); q_d.push_back(32'd30); end
            else if (endc == 2) begin q_a.push_back(32'h2000); q_d.push_back($urandom); end
            for (int i = 0; i < q_a.size(); i++) begin
                st(q_a[i], q_d[i]);
                repeat ($urandom_range(0, 2)) step();
            end
            step();
            model(exp_t);
            vecs++;
            if (obs !== exp_t) begin
                errs++; $display("FAIL random_%0d: got %h want %h", it, obs, exp_t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_ignore();
        test_early_done_overrun();
        test_timeout();
        test_wd_disabled();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
